// File: rtl/seq_shift_multiplier.sv
// -----------------------------------------------------------------------------
// seq_shift_multiplier
//
// Purpose:
//   Sequential shift-add multiplier for two N-bit operands. It does one
//   iteration per clock and finishes in N iterations. The accumulator/shift
//   register and its controlling FSM are merged into this one block. The
//   signed_mode input selects the algorithm for each operation:
//     0 : unsigned shift-add, where the extra accumulator bit holds the carry.
//     1 : signed radix-2 Booth, where the extra accumulator bit is a guard/sign
//         bit. This keeps M = -2^(N-1) exact.
//
// Ports:
//   clock         in   1    rising-edge clock
//   reset         in   1    asynchronous, active-low reset (0 = reset)
//   start         in   1    request a multiply (accepted in IDLE or DONE)
//   signed_mode   in   1    0 = unsigned, 1 = two's complement; captured with start
//   multiplicand  in   N    M operand, captured with start
//   multiplier    in   N    Q operand, captured with start
//   busy          out  1    high while iterating
//   done          out  1    one-cycle pulse when product is valid
//   product       out  2N   registered result, held until the next completion
// -----------------------------------------------------------------------------
module seq_shift_multiplier #(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] CountInit = CW'(N);
  localparam logic [CW-1:0] CountOne  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q;
  logic [N:0]      a_q;
  logic [N:0]      m_q;
  logic [N-1:0]    q_q;
  logic            q1_q;
  logic            mode_q;
  logic [CW-1:0]   count_q;
  logic            busy_q;
  logic            done_q;
  logic [2*N-1:0]  product_q;

  logic [N:0]      m_load;
  logic [N:0]      t_sum;
  logic [N:0]      a_d;
  logic [N-1:0]    q_d;
  logic            q1_d;

  // The multiplicand is widened to N+1 bits when it is captured.
  // Signed operations sign-extend it; unsigned operations zero-extend it.
  always_comb begin
    m_load = {1'b0, multiplicand};
    if (signed_mode) begin
      m_load = {multiplicand[N-1], multiplicand};
    end
  end

  // One iteration of the datapath. First the add/subtract step forms T in
  // N+1 bits. Then {T,Q} shifts right by one place. In unsigned mode a zero
  // fills the top bit. In Booth mode T's sign bit is replicated instead.
  always_comb begin
    t_sum = a_q;
    if (mode_q) begin
      case ({q_q[0], q1_q})
        2'b10:   t_sum = a_q - m_q;
        2'b01:   t_sum = a_q + m_q;
        default: t_sum = a_q;
      endcase
    end else if (q_q[0]) begin
      t_sum = a_q + m_q;
    end
    a_d  = {(mode_q ? t_sum[N] : 1'b0), t_sum[N:1]};
    q_d  = {t_sum[0], q_q[N-1:1]};
    q1_d = q_q[0];
  end

  // Controller and datapath registers. IDLE and DONE both accept a new
  // start, so a start held high runs operations back to back. The last
  // iteration writes the product from the post-shift values. This is why
  // product is never disturbed while RUN is in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      mode_q    <= 1'b0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          if (start) begin
            a_q     <= '0;
            m_q     <= m_load;
            q_q     <= multiplier;
            q1_q    <= 1'b0;
            mode_q  <= signed_mode;
            count_q <= CountInit;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q     <= a_d;
          q_q     <= q_d;
          q1_q    <= q1_d;
          count_q <= count_q - CountOne;
          if (count_q == CountOne) begin
            product_q <= {a_d[N-1:0], q_d};
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule
